// File: rtl/demux_lane_deser_if.sv
// rtl/demux_lane_deser_if.sv - bit-strobe input and per-lane word handshake bundle for demux_lane_deser
interface demux_lane_deser_if #(
  parameter int WIDTH = 8
);
  // Upstream demux side
  logic             in_vld;
  logic             s;
  logic             y0;
  logic             y1;
  logic             clr;
  // Lane-0 word channel
  logic [WIDTH-1:0] out0;
  logic             out0_vld;
  logic             out0_rdy;
  // Lane-1 word channel
  logic [WIDTH-1:0] out1;
  logic             out1_vld;
  logic             out1_rdy;
  // Sticky drop flags
  logic             ovf0;
  logic             ovf1;

  modport master (
    output in_vld, s, y0, y1, clr, out0_rdy, out1_rdy,
    input  out0, out0_vld, out1, out1_vld, ovf0, ovf1
  );

  modport slave (
    input  in_vld, s, y0, y1, clr, out0_rdy, out1_rdy,
    output out0, out0_vld, out1, out1_vld, ovf0, ovf1
  );
endinterface

// File: rtl/demux_lane_deser.sv
// rtl/demux_lane_deser.sv - two independent serial-to-parallel lanes fed by a 1:2 bit demux
module demux_lane_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_lane_deser_if.slave  bus
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]            bit_w;
  logic [1:0]            rdy_w;
  logic [1:0]            vld_w;
  logic [1:0]            ovf_w;
  logic [1:0][WIDTH-1:0] word_w;

  assign bit_w = {bus.y1, bus.y0};
  assign rdy_w = {bus.out1_rdy, bus.out0_rdy};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] shift_w;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;
    logic             take_w;
    logic             done_w;
    logic             free_w;

    // A bit belongs to this lane only when the select points here
    assign take_w = bus.in_vld & (bus.s == 1'(g));

    if (MSB_FIRST) begin : g_msb
      assign shift_w = {shreg_q[WIDTH-2:0], bit_w[g]};
    end else begin : g_lsb
      assign shift_w = {bit_w[g], shreg_q[WIDTH-1:1]};
    end

    // Word completes on the bit that wraps the counter; the holding
    // register can take it if empty or being drained this same cycle
    assign done_w = take_w & (cnt_q == LAST);
    assign free_w = ~vld_q | rdy_w[g];

    // Next-state: clear wins, then shifting, then load/drop/drain of the holding register
    always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      vld_d   = vld_q;
      ovf_d   = ovf_q;
      if (bus.clr) begin
        shreg_d = '0;
        cnt_d   = '0;
        word_d  = '0;
        vld_d   = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        if (take_w) begin
          shreg_d = shift_w;
          cnt_d   = done_w ? '0 : cnt_q + 1'b1;
        end
        if (done_w && free_w) begin
          word_d = shift_w;
          vld_d  = 1'b1;
        end else begin
          if (done_w) begin
            ovf_d = 1'b1;
          end
          if (vld_q && rdy_w[g]) begin
            vld_d = 1'b0;
          end
        end
      end
    end

    // Lane state registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shreg_q <= '0;
        cnt_q   <= '0;
        word_q  <= '0;
        vld_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        shreg_q <= shreg_d;
        cnt_q   <= cnt_d;
        word_q  <= word_d;
        vld_q   <= vld_d;
        ovf_q   <= ovf_d;
      end
    end

    assign word_w[g] = word_q;
    assign vld_w[g]  = vld_q;
    assign ovf_w[g]  = ovf_q;
  end

  assign bus.out0     = word_w[0];
  assign bus.out1     = word_w[1];
  assign bus.out0_vld = vld_w[0];
  assign bus.out1_vld = vld_w[1];
  assign bus.ovf0     = ovf_w[0];
  assign bus.ovf1     = ovf_w[1];

endmodule

// File: tb/tb_demux_lane_deser.sv
// tb/tb_demux_lane_deser.sv - directed and random checks of demux_lane_deser in both bit orders
module tb_demux_lane_deser;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic in_vld = 1'b0, s = 1'b0, y0 = 1'b0, y1 = 1'b0, clr = 1'b0;
  logic rdy0 = 1'b0, rdy1 = 1'b0;

  demux_lane_deser_if #(.WIDTH(W)) ifa ();
  demux_lane_deser_if #(.WIDTH(W)) ifb ();

  assign ifa.in_vld = in_vld;  assign ifb.in_vld = in_vld;
  assign ifa.s = s;            assign ifb.s = s;
  assign ifa.y0 = y0;          assign ifb.y0 = y0;
  assign ifa.y1 = y1;          assign ifb.y1 = y1;
  assign ifa.clr = clr;        assign ifb.clr = clr;
  assign ifa.out0_rdy = rdy0;  assign ifb.out0_rdy = rdy0;
  assign ifa.out1_rdy = rdy1;  assign ifb.out1_rdy = rdy1;

  demux_lane_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  demux_lane_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: index [d][lane], d=0 is MSB-first, d=1 is LSB-first
  int         m_n   [2][2];
  int         m_acc [2][2];
  logic [W-1:0] m_word[2][2];
  logic       m_vld [2][2];
  logic       m_ovf [2][2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 2; l++) begin
        m_n[d][l] = 0; m_acc[d][l] = 0; m_word[d][l] = '0;
        m_vld[d][l] = 1'b0; m_ovf[d][l] = 1'b0;
      end
  endtask

  task automatic model_step();
    if (!rst_n || clr) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 2; l++) begin
        logic rdy, b, complete;
        logic [W-1:0] nw;
        rdy = (l == 1) ? rdy1 : rdy0;
        b   = (l == 1) ? y1 : y0;
        complete = 1'b0;
        nw = '0;
        if (in_vld && (int'(s) == l)) begin
          if (d == 0) m_acc[d][l] = m_acc[d][l] * 2 + int'(b);
          else        m_acc[d][l] = m_acc[d][l] + (int'(b) << m_n[d][l]);
          m_n[d][l]++;
          if (m_n[d][l] == W) begin
            complete = 1'b1;
            nw = W'(m_acc[d][l]);
            m_n[d][l] = 0;
            m_acc[d][l] = 0;
          end
        end
        if (complete && (!m_vld[d][l] || rdy)) begin
          m_word[d][l] = nw;
          m_vld[d][l]  = 1'b1;
        end else begin
          if (complete) m_ovf[d][l] = 1'b1;
          if (m_vld[d][l] && rdy) m_vld[d][l] = 1'b0;
        end
      end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.out0",     ifa.out0,             m_word[0][0]);
    chk("a.out0_vld", W'(ifa.out0_vld),     W'(m_vld[0][0]));
    chk("a.ovf0",     W'(ifa.ovf0),         W'(m_ovf[0][0]));
    chk("a.out1",     ifa.out1,             m_word[0][1]);
    chk("a.out1_vld", W'(ifa.out1_vld),     W'(m_vld[0][1]));
    chk("a.ovf1",     W'(ifa.ovf1),         W'(m_ovf[0][1]));
    chk("b.out0",     ifb.out0,             m_word[1][0]);
    chk("b.out0_vld", W'(ifb.out0_vld),     W'(m_vld[1][0]));
    chk("b.ovf0",     W'(ifb.ovf0),         W'(m_ovf[1][0]));
    chk("b.out1",     ifb.out1,             m_word[1][1]);
    chk("b.out1_vld", W'(ifb.out1_vld),     W'(m_vld[1][1]));
    chk("b.ovf1",     W'(ifb.ovf1),         W'(m_ovf[1][1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    in_vld = 1'b0; s = 1'($urandom); y0 = 1'($urandom); y1 = 1'($urandom);
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    idle();
    clr = 1'b0;
  endtask

  task automatic send_bit(input int lane, input logic b);
    in_vld = 1'b1;
    s = (lane == 1);
    if (lane == 1) begin y1 = b; y0 = 1'($urandom); end
    else           begin y0 = b; y1 = 1'($urandom); end
    tick();
    in_vld = 1'b0;
  endtask

  task automatic send_word(input int lane, input logic [W-1:0] v, input bit msb_order, input int gaps);
    for (int i = 0; i < W; i++) begin
      send_bit(lane, msb_order ? v[W-1-i] : v[i]);
      if (i != W - 1) repeat ($urandom_range(0, gaps)) idle();
    end
  endtask

  initial begin
    logic [W-1:0] v0, v1;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst.out0", ifa.out0, 8'h00);
    rst_n = 1'b1;

    // Lane-0 byte A5, consumer always ready
    rdy0 = 1'b1; rdy1 = 1'b0;
    send_word(0, 8'hA5, 1'b1, 0);
    chk("t1.a.out0", ifa.out0, 8'hA5);
    chk("t1.a.vld",  W'(ifa.out0_vld), 8'h01);
    chk("t1.b.out0", ifb.out0, 8'hA5);
    idle();
    chk("t1.vld_drop", W'(ifa.out0_vld), 8'h00);
    chk("t1.lane1",    W'(ifa.out1_vld), 8'h00);

    // Interleaved lanes, LSB-first order, with gaps
    do_clr();
    rdy0 = 1'b0; rdy1 = 1'b0;
    v0 = 8'h3C; v1 = 8'hC3;
    for (int i = 0; i < W; i++) begin
      send_bit(0, v0[i]);
      repeat ($urandom_range(0, 2)) idle();
      send_bit(1, v1[i]);
      repeat ($urandom_range(0, 2)) idle();
    end
    chk("t2.b.out0", ifb.out0, 8'h3C);
    chk("t2.b.out1", ifb.out1, 8'hC3);
    chk("t2.a.out0", ifa.out0, 8'h3C);
    chk("t2.a.out1", ifa.out1, 8'hC3);

    // Backpressure on lane 1: second word dropped
    do_clr();
    rdy1 = 1'b0;
    send_word(1, 8'h11, 1'b1, 1);
    send_word(1, 8'h22, 1'b1, 1);
    chk("t3.out1", ifa.out1, 8'h11);
    chk("t3.ovf1", W'(ifa.ovf1), 8'h01);
    rdy1 = 1'b1;
    idle();
    chk("t3.vld_drop", W'(ifa.out1_vld), 8'h00);
    repeat (3) idle();
    chk("t3.no22", ifa.out1, 8'h11);

    // Back-to-back: drain and load on the same edge
    do_clr();
    rdy0 = 1'b0;
    send_word(0, 8'h5A, 1'b1, 0);
    v0 = 8'hC6;
    for (int i = 0; i < W - 1; i++) send_bit(0, v0[W-1-i]);
    rdy0 = 1'b1;
    send_bit(0, v0[0]);
    chk("t4.vld",  W'(ifa.out0_vld), 8'h01);
    chk("t4.out0", ifa.out0, 8'hC6);
    chk("t4.ovf0", W'(ifa.ovf0), 8'h00);

    // Partial word then clear
    do_clr();
    rdy0 = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(0, 1'b0);
    do_clr();
    send_word(0, 8'hFF, 1'b1, 0);
    chk("t5.out0", ifa.out0, 8'hFF);
    chk("t5.ovf0", W'(ifa.ovf0), 8'h00);

    // Asynchronous reset with held word and partial word
    do_clr();
    rdy1 = 1'b0; rdy0 = 1'b1;
    send_word(1, 8'h7E, 1'b1, 0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6.out1_vld", W'(ifa.out1_vld), 8'h00);
    chk("t6.out1",     ifa.out1, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_word(0, 8'h96, 1'b1, 0);
    chk("t6.a.out0", ifa.out0, 8'h96);
    chk("t6.a.vld",  W'(ifa.out0_vld), 8'h01);
    idle();
    chk("t6.one_word", W'(ifa.out0_vld), 8'h00);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      in_vld = ($urandom_range(0, 3) != 0);
      s  = 1'($urandom);
      y0 = 1'($urandom);
      y1 = 1'($urandom);
      rdy0 = ($urandom_range(0, 2) != 0);
      rdy1 = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 79) == 0);
      tick();
    end
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux_lane_deser.md
Name: demux_lane_deser

Overview:
- Consumes the two outputs of the 1:2 bit demultiplexer, together with its select and a bit-valid strobe.
- Deserializes each lane independently into WIDTH-bit words.
- Each assembled word is held in a per-lane output register with a valid/ready handshake.
- Sits directly downstream of the demux. It converts routed serial bits into parallel words for lane-0 and lane-1 consumers.

Parameters:
- WIDTH, 8: bits per assembled word (≥2).
- MSB_FIRST, 1: 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  bit strobe; y0/y1/s meaningful this cycle
- s  input  1  demux select; 0 = lane 0 carries the bit, 1 = lane 1
- y0  input  1  demux output lane 0
- y1  input  1  demux output lane 1
- clr  input  1  synchronous clear of counters, words, valids and sticky flags
- out0  output  WIDTH  lane-0 word
- out0_vld  output  1  lane-0 word valid
- out0_rdy  input  1  lane-0 consumer ready
- out1  output  WIDTH  lane-1 word
- out1_vld  output  1  lane-1 word valid
- out1_rdy  input  1  lane-1 consumer ready
- ovf0  output  1  sticky: lane-0 word dropped
- ovf1  output  1  sticky: lane-1 word dropped

Behaviour:
- Reset (rst_n=0, asynchronous): all shift registers and bit counters go to 0. out0, out1, out0_vld, out1_vld, ovf0 and ovf1 all go to 0. Release is synchronous to clk.
- Lane select: on a cycle with in_vld=1, s=0, y0 is shifted into lane 0 and y1 is ignored. With s=1, y1 is shifted into lane 1 and y0 is ignored. With in_vld=0, no lane changes its shift or count state.
- Shift order:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], bit}.
  - MSB_FIRST=0: shreg <= {bit, shreg[WIDTH-1:1]}.
- Per-lane counter: counts 0..WIDTH-1. It wraps to 0 on the cycle that accepts bit WIDTH-1, which is the word-complete event.
- Word complete, holding register free: the register is free when outN_vld=0, or when outN_vld=1 and outN_rdy=1 in the same cycle. The complete word, including the current bit, loads into outN. outN_vld=1 from the next cycle, so latency is 1 cycle after the last bit is sampled.
- Word complete, holding register busy (outN_vld=1, outN_rdy=0): the new word is discarded. outN and outN_vld are unchanged. ovfN is set and stays 1 until clr or reset. The counter still wraps, so the next bit starts a fresh word.
- Handshake: outN_vld=1 and outN_rdy=1 is a transfer.
  - Without a simultaneous load, outN_vld goes to 0 next cycle.
  - With a simultaneous load, outN_vld stays 1 and outN takes the new word.
  - outN is stable while outN_vld=1 and outN_rdy=0.
- Lanes are fully independent. A partial word on one lane is preserved across any number of bits on the other lane.
- clr=1: next edge zeroes counters, shift registers, outN, outN_vld and ovfN. clr takes priority over any same-cycle bit or handshake. A partial word in flight is lost.
- Reset mid-word or with a held word: everything is lost; no word is emitted after release.
- outN_rdy is ignored while outN_vld=0.

Test Plan:
- Lane-0 byte, WIDTH=8, MSB_FIRST=1, out0_rdy=1: 8 bits 1,0,1,0,0,1,0,1 with s=0, in_vld=1 on consecutive cycles -> out0=8'hA5, out0_vld high exactly 1 cycle, one cycle after the 8th bit; lane 1 untouched.
- Interleaved lanes, MSB_FIRST=0: lane-0 bits of 8'h3C alternate with lane-1 bits of 8'hC3 (s toggling each cycle, in_vld gaps inserted) -> out0=8'h3C, out1=8'hC3; each lane's bit order is correct despite gaps.
- Backpressure: out1_rdy=0, two full lane-1 words 8'h11 then 8'h22 -> out1 holds 8'h11 with out1_vld=1; ovf1=1 after the second word completes; then out1_rdy=1 -> 8'h11 transfers, out1_vld drops, 8'h22 never appears.
- Back-to-back transfer: out0_vld=1, with out0_rdy=1 on the same cycle as the next word completes -> out0_vld stays 1 and out0 updates to the new word, with no bubble and no overflow.
- Partial word then clr: 5 lane-0 bits, then clr=1 for one cycle, then 8 bits of 8'hFF -> out0=8'hFF; the old partial bits are absent and ovf0=0.
- Async reset: assert rst_n=0 mid-cycle with out1_vld=1 and a 3-bit partial word on lane 0 -> all outputs 0 immediately; after release, 8 new lane-0 bits produce exactly one correct word.
